// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types for the multiply/divide unit
//
// Purpose: operation and FSM state encodings used by mult_div_unit, plus
// small decode helpers so the op bit meanings live in one place.
// Ports: none (package).

package mips_pkg;

   // bit 1 selects divide, bit 0 selects unsigned
   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_FIX  = 2'b10,
      MD_DONE = 2'b11
   } md_state_t;

   function automatic logic md_is_div(input md_op_t op);
      return op[1];
   endfunction

   function automatic logic md_is_signed(input md_op_t op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational multiply/divide iteration
//
// Purpose: computes the next value of the 2*WIDTH working register for a
// single shift-add (multiply) or restoring shift-subtract (divide) step.
// Both operations work on unsigned magnitudes; signs are fixed up later.
// Ports:
//   is_div  in   1          1 = divide step, 0 = multiply step
//   work    in   2*WIDTH    working register {upper, lower}
//   opnd    in   WIDTH      multiplicand or divisor magnitude
//   work_nx out  2*WIDTH    working register after this step

module md_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] work,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] work_nx
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             take;

   always_comb begin
      // multiply: upper half accumulates (with carry) then the whole
      // register shifts right, consuming one multiplier bit from work[0]
      sum    = {1'b0, work[2*WIDTH-1:WIDTH]} +
               (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

      // divide: partial remainder shifted left with the next dividend bit;
      // remainder stays below the divisor so the difference fits WIDTH bits
      rem_sh = work[2*WIDTH-1:WIDTH-1];
      take   = (rem_sh >= {1'b0, opnd});
      diff   = rem_sh[WIDTH-1:0] - opnd;

      if (is_div) begin
         work_nx = {(take ? diff : rem_sh[WIDTH-1:0]), work[WIDTH-2:0], take};
      end else begin
         work_nx = {sum, work[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO
//
// Purpose: sequential multiplier/divider producing HI/LO. One iteration per
// cycle in RUN, sign correction and HI/LO write in FIX, one-cycle done in
// DONE. Direct HI/LO writes are accepted only while not busy.
// Ports:
//   clk       in   1      system clock, rising edge
//   reset_n   in   1      asynchronous active-low reset
//   start     in   1      launch request, honoured in IDLE only
//   op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      in   WIDTH  multiplicand/dividend, multiplier/divisor
//   abort     in   1      cancel operation in RUN or FIX
//   hi_we     in   1      direct HI write enable
//   lo_we     in   1      direct LO write enable
//   wdata     in   WIDTH  direct write data
//   hi, lo    out  WIDTH  result registers
//   busy      out  1      high in RUN and FIX
//   done      out  1      one-cycle completion pulse
//   div_zero  out  1      last completed operation divided by zero

module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   md_state_t          state_q, state_d;
   md_op_t             op_q, op_in;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] work_q, work_nx, prod_fix;
   logic [WIDTH-1:0]   opnd_q, a_q, hi_q, lo_q;
   logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, fix_hi, fix_lo;
   logic               neg_q, neg_rem_q, dz_q, fix_dz, is_div_q, wr_ok;

   assign op_in    = md_op_t'(op);
   assign is_div_q = md_is_div(op_q);
   assign wr_ok    = (state_q == MD_IDLE) || (state_q == MD_DONE);

   // magnitudes: absolute value for signed ops; the most-negative value
   // negates to itself, which is already its correct unsigned magnitude
   always_comb begin
      a_mag = a;
      b_mag = b;
      if (md_is_signed(op_in) && a[WIDTH-1]) a_mag = -a;
      if (md_is_signed(op_in) && b[WIDTH-1]) b_mag = -b;
   end

   md_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div_q),
      .work    (work_q),
      .opnd    (opnd_q),
      .work_nx (work_nx)
   );

   // sign correction of the finished magnitude result
   always_comb begin
      fix_hi   = '0;
      fix_lo   = '0;
      fix_dz   = 1'b0;
      prod_fix = neg_q ? -work_q : work_q;
      quo      = work_q[WIDTH-1:0];
      rem      = work_q[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         if (opnd_q == '0) begin
            fix_hi = a_q;
            fix_lo = '1;
            fix_dz = 1'b1;
         end else begin
            fix_hi = neg_rem_q ? -rem : rem;
            fix_lo = neg_q ? -quo : quo;
         end
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= MD_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start) state_d = MD_RUN;
         MD_RUN: begin
            if (abort)             state_d = MD_IDLE;
            else if (cnt_q == '0)  state_d = MD_FIX;
         end
         MD_FIX:  state_d = abort ? MD_IDLE : MD_DONE;
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q      <= MD_MULT;
         cnt_q     <= '0;
         work_q    <= '0;
         opnd_q    <= '0;
         a_q       <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         dz_q      <= 1'b0;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (start) begin
                  op_q      <= op_in;
                  a_q       <= a;
                  opnd_q    <= b_mag;
                  work_q    <= {{WIDTH{1'b0}}, a_mag};
                  cnt_q     <= CW'(WIDTH - 1);
                  neg_q     <= md_is_signed(op_in) & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_q <= md_is_signed(op_in) & md_is_div(op_in) & a[WIDTH-1];
               end
            end
            MD_RUN: begin
               if (!abort) begin
                  work_q <= work_nx;
                  if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
               end
            end
            MD_FIX: begin
               if (!abort) begin
                  hi_q <= fix_hi;
                  lo_q <= fix_lo;
                  dz_q <= fix_dz;
               end
            end
            default: ;
         endcase
         // direct writes never coincide with the FIX result write
         if (wr_ok && hi_we) hi_q <= wdata;
         if (wr_ok && lo_we) lo_q <= wdata;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = (state_q == MD_RUN) || (state_q == MD_FIX);
   assign done     = (state_q == MD_DONE);
   assign div_zero = dz_q;

endmodule
